alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the lab 4-bit combinational ALU: N-bit operands, 2N-bit registered result, a start/busy/done handshake, and a multi-cycle shift-add multiplier. Sits between the switch/key input stage and the HEX display driver. The result register optionally feeds back as the B operand so chained operations accumulate.

## Interface
- N, default 4: operand width; ≥2. Result width is 2N.
- Clock  in  1  rising-edge clock; the only clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  operation request; sampled on the rising edge.
- Function  in  3  operation select; sampled with Start.
- A  in  N  operand A.
- B  in  N  operand B.
- UseAcc  in  1  selects ALUOut[N-1:0] as operand B; sampled with Start. Honoured only under ALU_ACC_EN.
- ALUOut  out  2N  registered result.
- Busy  out  1  multiply in progress; Start is ignored while high.
- Done  out  1  one-cycle pulse: ALUOut has just been updated.

## Operation
- Accept: rising edge with Start=1 and Busy=0. Function, A and B (or the accumulator) are captured at that edge. Start while Busy=1 is dropped with no effect and no queueing.
- Function codes (Bop = effective B):
  - 000: {(N-1)'b0, A+Bop}. The N+1-bit sum is zero-extended.
  - 001: 2N'(|{A,Bop}). Bit 0 only; upper bits are 0.
  - 010: 2N'(&{A,Bop}). Bit 0 only.
  - 011: {A,Bop}.
  - 100: A×Bop, unsigned, full 2N bits. Multi-cycle.
  - 101: {N'b0,Bop} << A. A is an unsigned shift amount; amounts ≥2N give 0.
  - 110: {A,Bop} >> Bop. Logical shift; amounts ≥2N give 0.
  - 111: clear. ALUOut=0.
- All codes are defined. There is no default/X case.
- State machine, two states:
  - IDLE: Busy=0. An accepted code other than 100 writes ALUOut at the accept edge. An accepted 100 loads the multiplicand, multiplier and a zeroed partial product, sets the cycle counter to 0, and moves to MUL.
  - MUL: Busy=1. Each edge conditionally adds the shifted multiplicand and shifts the multiplier; the counter increments. At the edge where the counter reaches N-1, the product is written to ALUOut and the machine returns to IDLE.
  - During MUL, ALUOut holds its previous value until the final edge.
- Done is 1 in the cycle following any edge that writes ALUOut, and 0 otherwise.
- Reset, asynchronous, including mid-multiply:
  - ALUOut=0, Busy=0, Done=0, state=IDLE, counter=0, internal operands cleared.
  - The interrupted multiply is lost; no Done is produced for it.

## Timing
- Single-cycle ops: accept at edge k; ALUOut valid and Done=1 during cycle k→k+1.
- Multiply: accept at edge k; Busy=1 from k to k+N. ALUOut is written and Done=1 after edge k+N, with Busy=0 in the same cycle. Latency is N cycles.
- Back-to-back:
  - A Start in the Done cycle is accepted, because Busy=0 there.
  - Single-cycle ops sustain one per cycle, with Done held high continuously.
- Accumulator chaining: UseAcc reads ALUOut as registered before the accept edge, so consecutive single-cycle ops chain without stalls.
- No combinational path from any input to any output.

## Configuration
- ALU_ACC_EN defined:
  - UseAcc=1 makes Bop = ALUOut[N-1:0] for every function, including multiply. The value is captured at accept.
- ALU_ACC_EN undefined:
  - UseAcc is ignored and Bop = B always.
  - The port remains present so the top level is unchanged.

## Test plan
- N=4, A=4'hF, B=4'h1, Function=000, one-cycle Start → next cycle ALUOut=8'h10, Done=1, Busy=0. Following cycle Done=0.
- N=4, A=4'hF, B=4'hF, Function=100, Start → Busy=1 for 4 cycles; then ALUOut=8'hE1, Done=1. Same with A=4'h0 → 8'h00 after 4 cycles.
- Multiply in progress (A=4'h7, B=4'h3); Start with Function=000 two cycles after accept → ignored; ALUOut=8'h15 at cycle 4; exactly one Done pulse.
- Functions 001, 010, 011, 101, 110, 111:
  - A=4'h0, B=4'h0, 001 → 8'h00. A=4'hF, B=4'hF, 010 → 8'h01. A=4'hA, B=4'h5, 011 → 8'hA5.
  - A=4'h2, B=4'h3, 101 → 8'h0C. A=4'hA, B=4'h5, 110 → 8'h05.
  - 111 → 8'h00.
- Reset asserted asynchronously (mid-cycle) two cycles into a multiply → ALUOut=0, Busy=0, Done=0 immediately. After release, Function=000 with A=4'h1, B=4'h1 → 8'h02.
- ALU_ACC_EN defined; reset; then three consecutive Start cycles with Function=000, A=4'h1, UseAcc=1 → ALUOut 8'h01, 8'h02, 8'h03, Done high all three cycles. Without the macro, B=4'h0 → 8'h01 each time.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered N-bit ALU with start/busy/done handshake and shift-add multiplier
// Optional feature macro: ALU_ACC_EN (UseAcc selects ALUOut[N-1:0] as operand B).
module alu_seq #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [2:0]     Function,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           UseAcc,
  output logic [2*N-1:0] ALUOut,
  output logic           Busy,
  output logic           Done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state, next_state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] mcand, prod, prod_next, res;
  logic [N-1:0]   mplier, bop;
  logic           accept, mul_last;

`ifdef ALU_ACC_EN
  assign bop = UseAcc ? ALUOut[N-1:0] : B;
`else
  logic unused_use_acc;
  assign unused_use_acc = UseAcc;
  assign bop = B;
`endif

  assign accept    = Start && (state == IDLE);
  assign mul_last  = (state == MUL) && (cnt == LAST);
  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign Busy      = (state == MUL);

  always_comb begin
    res = '0;
    case (Function)
      3'b000: res = {{(N-1){1'b0}}, ({1'b0, A} + {1'b0, bop})};
      3'b001: res = {{(2*N-1){1'b0}}, |{A, bop}};
      3'b010: res = {{(2*N-1){1'b0}}, &{A, bop}};
      3'b011: res = {A, bop};
      3'b100: res = '0;
      3'b101: res = {{N{1'b0}}, bop} << A;
      3'b110: res = {A, bop} >> bop;
      3'b111: res = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && Function == 3'b100) next_state = MUL;
      MUL:  if (mul_last) next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ALUOut <= '0;
      Done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        if (Function == 3'b100) begin
          mcand  <= {{N{1'b0}}, A};
          mplier <= bop;
          prod   <= '0;
          cnt    <= '0;
        end else begin
          ALUOut <= res;
          Done   <= 1'b1;
        end
      end else if (state == MUL) begin
        // One multiplier bit per cycle; the final edge commits the accumulated product.
        prod   <= prod_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          ALUOut <= prod_next;
          Done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (N=4)
module tb_alu_seq;

  localparam int N = 4;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Start = 1'b0;
  logic [2:0]     Function = 3'b000;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic           UseAcc = 1'b0;
  logic [2*N-1:0] ALUOut;
  logic           Busy;
  logic           Done;

  int errors = 0;
  int checks = 0;

  alu_seq #(.N(N)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Function(Function),
    .A(A), .B(B), .UseAcc(UseAcc), .ALUOut(ALUOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp);
    Function = f; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq(tag, ALUOut, exp);
    check_eq({tag, "_done"}, Done, 1);
    check_eq({tag, "_busy"}, Busy, 0);
  endtask

  int pulses;

  initial begin
    #12;
    check_eq("rst_out", ALUOut, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    Reset = 1'b0;
    tick();

    // 4'hF + 4'h1 carries into bit 4
    do_op("add_carry", 3'b000, 4'hF, 4'h1, 8'h10);
    tick();
    check_eq("add_done_drop", Done, 0);

    // F*F: busy four cycles, result held until the last edge
    Function = 3'b100; A = 4'hF; B = 4'hF; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("mulff_busy%0d", i), Busy, 1);
      check_eq($sformatf("mulff_hold%0d", i), ALUOut, 8'h10);
      check_eq($sformatf("mulff_nodone%0d", i), Done, 0);
      if (i < 3) tick();
    end
    tick();
    check_eq("mulff_out", ALUOut, 8'hE1);
    check_eq("mulff_done", Done, 1);
    check_eq("mulff_idle", Busy, 0);

    // 0*F after four cycles
    Function = 3'b100; A = 4'h0; B = 4'hF; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("mul0_hold", ALUOut, 8'hE1);
    tick();
    check_eq("mul0_out", ALUOut, 8'h00);
    check_eq("mul0_done", Done, 1);

    // 7*3 with a Start dropped while busy
    Function = 3'b100; A = 4'h7; B = 4'h3; Start = 1'b1;
    tick();
    Start = 1'b0;
    pulses = 0;
    tick();
    pulses += int'(Done);
    Function = 3'b000; A = 4'h1; B = 4'h1; Start = 1'b1;
    tick();
    Start = 1'b0;
    pulses += int'(Done);
    check_eq("mul73_still_busy", Busy, 1);
    tick();
    pulses += int'(Done);
    tick();
    pulses += int'(Done);
    check_eq("mul73_out", ALUOut, 8'h15);
    check_eq("mul73_done", Done, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(Done);
    end
    check_eq("mul73_pulses", pulses, 1);
    check_eq("mul73_keep", ALUOut, 8'h15);

    // asynchronous reset two cycles into a multiply
    Function = 3'b100; A = 4'h3; B = 4'h3; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    #2 Reset = 1'b1;
    #1;
    check_eq("arst_out", ALUOut, 0);
    check_eq("arst_busy", Busy, 0);
    check_eq("arst_done", Done, 0);
    Reset = 1'b0;
    tick();
    check_eq("arst_no_done", Done, 0);
    do_op("arst_add", 3'b000, 4'h1, 4'h1, 8'h02);

    do_op("or_zero",  3'b001, 4'h0, 4'h0, 8'h00);
    do_op("or_one",   3'b001, 4'h4, 4'h0, 8'h01);
    do_op("and_all",  3'b010, 4'hF, 4'hF, 8'h01);
    do_op("and_part", 3'b010, 4'hF, 4'hE, 8'h00);
    do_op("concat",   3'b011, 4'hA, 4'h5, 8'hA5);
    do_op("shl",      3'b101, 4'h2, 4'h3, 8'h0C);
    do_op("shl_big",  3'b101, 4'h8, 4'hF, 8'h00);
    do_op("shr",      3'b110, 4'hA, 4'h5, 8'h05);
    do_op("shr_big",  3'b110, 4'hF, 4'h9, 8'h00);
    do_op("clear",    3'b111, 4'hA, 4'h5, 8'h00);

    // three back-to-back accepts with UseAcc
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Function = 3'b000; A = 4'h1; B = 4'h0; UseAcc = 1'b1; Start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
`ifdef ALU_ACC_EN
      check_eq($sformatf("acc_out%0d", i), ALUOut, i);
`else
      check_eq($sformatf("acc_out%0d", i), ALUOut, 8'h01);
`endif
      check_eq($sformatf("acc_done%0d", i), Done, 1);
    end
    Start = 1'b0;
    UseAcc = 1'b0;
    tick();
    check_eq("acc_done_end", Done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
